// File: rtl/xpmwrap_dpdistram_porta_arbiter.sv
// Round-robin arbiter sharing port A of a 2-cycle dual-port distributed RAM.
// Two valid/ready requesters, one RAM access per cycle, read data routed back.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   arb_en                gate for new grants (in-flight reads still return)
//   reqN_valid/ready      request handshake, N = 0,1
//   reqN_we/addr/wdata    byte write mask (0 = read), address, write data
//   rspN_valid/data       one-cycle read response, data held while idle
//   ram_*                 RAM port A (ena, wea, addra, dina, regcea, rsta, douta)
// Optional (`XPMWRAP_DPDISTRAM_ARB_STATS_EN):
//   stat_clr              synchronous clear of the counters
//   stat_grant0/1         saturating grant counters
//   stat_conflict         saturating count of cycles with both requesting

module xpmwrap_dpdistram_porta_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arb_en,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   req0_we,
  input  logic [ADDR_WIDTH-1:0]              req0_addr,
  input  logic [DATA_WIDTH-1:0]              req0_wdata,
  output logic                               rsp0_valid,
  output logic [DATA_WIDTH-1:0]              rsp0_data,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   req1_we,
  input  logic [ADDR_WIDTH-1:0]              req1_addr,
  input  logic [DATA_WIDTH-1:0]              req1_wdata,
  output logic                               rsp1_valid,
  output logic [DATA_WIDTH-1:0]              rsp1_data,
  output logic                               ram_ena,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0]   ram_wea,
  output logic [ADDR_WIDTH-1:0]              ram_addra,
  output logic [DATA_WIDTH-1:0]              ram_dina,
  output logic                               ram_regcea,
  output logic                               ram_rsta,
  input  logic [DATA_WIDTH-1:0]              ram_douta
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  ,
  input  logic                               stat_clr,
  output logic [15:0]                        stat_grant0,
  output logic [15:0]                        stat_grant1,
  output logic [15:0]                        stat_conflict
`endif
);

  localparam int NBE = DATA_WIDTH / BYTE_WIDTH;

  logic            last_grant;
  logic            gnt0;
  logic            gnt1;
  logic            gnt_any;
  logic            gnt_rd;
  logic            s1_rd;
  logic            s1_id;
  logic            s2_rd;
  logic            s2_id;
  logic [DATA_WIDTH-1:0] hold0;
  logic [DATA_WIDTH-1:0] hold1;

  // last_grant = 1 means requester 1 won most recently
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_en) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign gnt_any    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = '0;
    ram_addra = '0;
    ram_dina  = '0;
    unique case (1'b1)
      gnt0: begin
        ram_ena   = 1'b1;
        ram_wea   = req0_we;
        ram_addra = req0_addr;
        ram_dina  = req0_wdata;
      end
      gnt1: begin
        ram_ena   = 1'b1;
        ram_wea   = req1_we;
        ram_addra = req1_addr;
        ram_dina  = req1_wdata;
      end
      default: ;
    endcase
  end

  assign gnt_rd     = gnt_any & (ram_wea == '0);
  assign ram_regcea = 1'b1;
  assign ram_rsta   = ~rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt_any) begin
      last_grant <= gnt1;
    end
  end

  // tag pipeline mirrors the RAM's two-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd <= 1'b0;
      s1_id <= 1'b0;
      s2_rd <= 1'b0;
      s2_id <= 1'b0;
    end else begin
      s1_rd <= gnt_rd;
      s1_id <= gnt1;
      s2_rd <= s1_rd;
      s2_id <= s1_id;
    end
  end

  assign rsp0_valid = s2_rd & ~s2_id;
  assign rsp1_valid = s2_rd & s2_id;

  // douta is live only in the response cycle; keep a copy for idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rsp0_valid) hold0 <= ram_douta;
      if (rsp1_valid) hold1 <= ram_douta;
    end
  end

  assign rsp0_data = rsp0_valid ? ram_douta : hold0;
  assign rsp1_data = rsp1_valid ? ram_douta : hold1;

`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  logic conflict;
  assign conflict = arb_en & req0_valid & req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_grant0 != 16'hFFFF)
        stat_grant0 <= stat_grant0 + 16'd1;
      if (gnt1 && stat_grant1 != 16'hFFFF)
        stat_grant1 <= stat_grant1 + 16'd1;
      if (conflict && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

  logic unused_nbe;
  assign unused_nbe = (NBE == 0);

endmodule

// File: tb/tb_xpmwrap_dpdistram_porta_arbiter.sv
// Directed bench for the port A arbiter.
// Includes a behavioural write-first RAM with two-cycle read latency.

module tb_xpmwrap_dpdistram_porta_arbiter;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int NBE = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arb_en = 1'b0;
  logic           req0_valid = 1'b0;
  logic           req0_ready;
  logic [NBE-1:0] req0_we = '0;
  logic [AW-1:0]  req0_addr = '0;
  logic [DW-1:0]  req0_wdata = '0;
  logic           rsp0_valid;
  logic [DW-1:0]  rsp0_data;
  logic           req1_valid = 1'b0;
  logic           req1_ready;
  logic [NBE-1:0] req1_we = '0;
  logic [AW-1:0]  req1_addr = '0;
  logic [DW-1:0]  req1_wdata = '0;
  logic           rsp1_valid;
  logic [DW-1:0]  rsp1_data;
  logic           ram_ena;
  logic [NBE-1:0] ram_wea;
  logic [AW-1:0]  ram_addra;
  logic [DW-1:0]  ram_dina;
  logic           ram_regcea;
  logic           ram_rsta;
  logic [DW-1:0]  ram_douta;
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  logic           stat_clr = 1'b0;
  logic [15:0]    stat_grant0;
  logic [15:0]    stat_grant1;
  logic [15:0]    stat_conflict;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xpmwrap_dpdistram_porta_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BYTE_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .ram_ena    (ram_ena),
    .ram_wea    (ram_wea),
    .ram_addra  (ram_addra),
    .ram_dina   (ram_dina),
    .ram_regcea (ram_regcea),
    .ram_rsta   (ram_rsta),
    .ram_douta  (ram_douta)
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  // write-first RAM, two output register stages
  logic [DW-1:0] mem [64];
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
  logic [DW-1:0] w;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    p1 = '0;
    p2 = '0;
  end

  assign ram_douta = p2;

  always @(posedge clk) begin
    w = mem[ram_addra];
    if (ram_ena) begin
      for (int b = 0; b < NBE; b++)
        if (ram_wea[b]) w[b*8 +: 8] = ram_dina[b*8 +: 8];
      if (ram_wea != '0) mem[ram_addra] <= w;
      p1 <= w;
    end
    p2 <= p1;
  end

  function automatic logic [DW-1:0] dat(int a);
    return 32'hC0DE0000 + 32'(a);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_we    = '0;
    req1_we    = '0;
    req0_addr  = '0;
    req1_addr  = '0;
    req0_wdata = '0;
    req1_wdata = '0;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    arb_en = 1'b1;
    idle();
    @(negedge clk);
    n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp0_valid got %0h want 0", rsp0_valid); end
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp1_valid got %0h want 0", rsp1_valid); end
    n_tests++; if (rsp0_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp0_data got %h want 0", rsp0_data); end
    n_tests++; if (rsp1_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp1_data got %h want 0", rsp1_data); end
    n_tests++; if (ram_rsta !== 1'b1) begin n_fail++; $display("FAIL rst_rsta got %0h want 1", ram_rsta); end
    n_tests++; if (ram_regcea !== 1'b1) begin n_fail++; $display("FAIL regcea got %0h want 1", ram_regcea); end
    n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ena got %0h want 0", ram_ena); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (ram_rsta !== 1'b0) begin n_fail++; $display("FAIL rel_rsta got %0h want 0", ram_rsta); end
    step();
  endtask

  task automatic test_write_read;
    req0_valid = 1'b1;
    req0_we    = 4'hF;
    req0_addr  = 6'd5;
    req0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready0 got %0h want 1", req0_ready); end
    n_tests++; if (ram_ena !== 1'b1) begin n_fail++; $display("FAIL wr_ena got %0h want 1", ram_ena); end
    n_tests++; if (ram_wea !== 4'hF) begin n_fail++; $display("FAIL wr_wea got %h want f", ram_wea); end
    n_tests++; if (ram_addra !== 6'd5) begin n_fail++; $display("FAIL wr_addr got %0d want 5", ram_addra); end
    n_tests++; if (ram_dina !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_din got %h want deadbeef", ram_dina); end
    step();
    idle();
    @(negedge clk);
    n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL idle_ena got %0h want 0", ram_ena); end
    n_tests++; if (ram_addra !== 6'd0) begin n_fail++; $display("FAIL idle_addr got %0d want 0", ram_addra); end
    n_tests++; if (ram_dina !== 32'h0) begin n_fail++; $display("FAIL idle_din got %h want 0", ram_dina); end
    step();
    req1_valid = 1'b1;
    req1_addr  = 6'd5;
    @(negedge clk);
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready1 got %0h want 1", req1_ready); end
    n_tests++; if (ram_wea !== 4'h0) begin n_fail++; $display("FAIL rd_wea got %h want 0", ram_wea); end
    step();
    idle();
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early got %0h want 0", rsp1_valid); end
    step();
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp1_valid got %0h want 1", rsp1_valid); end
    n_tests++; if (rsp1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp1_data got %h want deadbeef", rsp1_data); end
    n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp0_valid got %0h want 0", rsp0_valid); end
    step();
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rd_one_cycle got %0h want 0", rsp1_valid); end
    n_tests++; if (rsp1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got %h want deadbeef", rsp1_data); end
    step();
  endtask

  task automatic test_byte_write;
    req0_valid = 1'b1;
    req0_we    = 4'hF;
    req0_addr  = 6'd3;
    req0_wdata = 32'h11223344;
    step();
    req0_we    = 4'b0010;
    req0_wdata = 32'hAABBCCDD;
    step();
    req0_we    = 4'h0;
    req0_wdata = 32'h0;
    @(negedge clk);
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bw_ready0 got %0h want 1", req0_ready); end
    step();
    idle();
    step();
    @(negedge clk);
    n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL bw_valid got %0h want 1", rsp0_valid); end
    n_tests++; if (rsp0_data !== 32'h1122CC44) begin n_fail++; $display("FAIL bw_data got %h want 1122cc44", rsp0_data); end
    step();
  endtask

  task automatic test_round_robin;
    int i0;
    int i1;
    int id;
    logic g0;
    logic g1;
    for (int a = 10; a < 16; a++) begin
      req1_valid = 1'b1;
      req1_we    = 4'hF;
      req1_addr  = 6'(a);
      req1_wdata = dat(a);
      @(negedge clk);
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL pre_ready1 a=%0d got %0h want 1", a, req1_ready); end
      step();
    end
    idle();
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      req0_valid = (i0 < 3);
      req0_addr  = 6'(10 + 2 * i0);
      req1_valid = (i1 < 3);
      req1_addr  = 6'(11 + 2 * i1);
      @(negedge clk);
      if (k < 6) begin
        n_tests++; if (req0_ready !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_ready0 k=%0d got %0h", k, req0_ready); end
        n_tests++; if (req1_ready !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_ready1 k=%0d got %0h", k, req1_ready); end
        n_tests++; if (ram_addra !== 6'(10 + k)) begin n_fail++; $display("FAIL rr_addr k=%0d got %0d want %0d", k, ram_addra, 10 + k); end
      end else begin
        n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL rr_ena k=%0d got %0h want 0", k, ram_ena); end
      end
      if (k >= 2) begin
        id = (k - 2) % 2;
        n_tests++; if (rsp0_valid !== (id == 0)) begin n_fail++; $display("FAIL rr_rsp0_valid k=%0d got %0h", k, rsp0_valid); end
        n_tests++; if (rsp1_valid !== (id == 1)) begin n_fail++; $display("FAIL rr_rsp1_valid k=%0d got %0h", k, rsp1_valid); end
        if (id == 0) begin
          n_tests++; if (rsp0_data !== dat(8 + k)) begin n_fail++; $display("FAIL rr_rsp0_data k=%0d got %h want %h", k, rsp0_data, dat(8 + k)); end
        end else begin
          n_tests++; if (rsp1_data !== dat(8 + k)) begin n_fail++; $display("FAIL rr_rsp1_data k=%0d got %h want %h", k, rsp1_data, dat(8 + k)); end
        end
      end else begin
        n_tests++; if ((rsp0_valid | rsp1_valid) !== 1'b0) begin n_fail++; $display("FAIL rr_no_rsp k=%0d got %0h%0h", k, rsp0_valid, rsp1_valid); end
      end
      g0 = req0_ready;
      g1 = req1_ready;
      step();
      if (g0) i0++;
      if (g1) i1++;
    end
    idle();
  endtask

  task automatic test_arb_en;
    req0_valid = 1'b1;
    req0_addr  = 6'd10;
    @(negedge clk);
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready0 got %0h want 1", req0_ready); end
    step();
    arb_en     = 1'b0;
    req0_addr  = 6'd12;
    req1_valid = 1'b1;
    req1_addr  = 6'd11;
    @(negedge clk);
    n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready0 got %0h want 0", req0_ready); end
    n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready1 got %0h want 0", req1_ready); end
    n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL dis_ena got %0h want 0", ram_ena); end
    step();
    @(negedge clk);
    n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL dis_rsp0_valid got %0h want 1", rsp0_valid); end
    n_tests++; if (rsp0_data !== dat(10)) begin n_fail++; $display("FAIL dis_rsp0_data got %h want %h", rsp0_data, dat(10)); end
    n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready0b got %0h want 0", req0_ready); end
    step();
    arb_en = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL en_rsp0_once got %0h want 0", rsp0_valid); end
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready1 got %0h want 1", req1_ready); end
    step();
    idle();
    step();
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL en_rsp1_valid got %0h want 1", rsp1_valid); end
    n_tests++; if (rsp1_data !== dat(11)) begin n_fail++; $display("FAIL en_rsp1_data got %h want %h", rsp1_data, dat(11)); end
    step();
  endtask

  task automatic test_reset_mid;
    req1_valid = 1'b1;
    req1_addr  = 6'd13;
    @(negedge clk);
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready1 got %0h want 1", req1_ready); end
    step();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp1_n1 got %0h want 0", rsp1_valid); end
    step();
    @(negedge clk);
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp1_n2 got %0h want 0", rsp1_valid); end
    n_tests++; if (rsp1_data !== 32'h0) begin n_fail++; $display("FAIL rm_rsp1_data got %h want 0", rsp1_data); end
    rst_n = 1'b1;
    step();
    req0_valid = 1'b1;
    req0_addr  = 6'd10;
    req1_valid = 1'b1;
    req1_addr  = 6'd11;
    @(negedge clk);
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rm_first0 got %0h want 1", req0_ready); end
    n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rm_first1 got %0h want 0", req1_ready); end
    step();
    idle();
    step();
    @(negedge clk);
    n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL rm_rsp0_valid got %0h want 1", rsp0_valid); end
    n_tests++; if (rsp0_data !== dat(10)) begin n_fail++; $display("FAIL rm_rsp0_data got %h want %h", rsp0_data, dat(10)); end
    step();
  endtask

`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  task automatic test_stats;
    idle();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    n_tests++; if (stat_conflict !== 16'd0) begin n_fail++; $display("FAIL st_clr0_conf got %0d want 0", stat_conflict); end
    n_tests++; if (stat_grant0 !== 16'd0) begin n_fail++; $display("FAIL st_clr0_g0 got %0d want 0", stat_grant0); end
    n_tests++; if (stat_grant1 !== 16'd0) begin n_fail++; $display("FAIL st_clr0_g1 got %0d want 0", stat_grant1); end
    req0_valid = 1'b1;
    req0_addr  = 6'd10;
    req1_valid = 1'b1;
    req1_addr  = 6'd11;
    for (int c = 0; c < 4; c++) step();
    idle();
    @(negedge clk);
    n_tests++; if (stat_conflict !== 16'd4) begin n_fail++; $display("FAIL st_conf got %0d want 4", stat_conflict); end
    n_tests++; if (stat_grant0 !== 16'd2) begin n_fail++; $display("FAIL st_g0 got %0d want 2", stat_grant0); end
    n_tests++; if (stat_grant1 !== 16'd2) begin n_fail++; $display("FAIL st_g1 got %0d want 2", stat_grant1); end
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    n_tests++; if (stat_conflict !== 16'd0) begin n_fail++; $display("FAIL st_clr_conf got %0d want 0", stat_conflict); end
    n_tests++; if (stat_grant0 !== 16'd0) begin n_fail++; $display("FAIL st_clr_g0 got %0d want 0", stat_grant0); end
    n_tests++; if (stat_grant1 !== 16'd0) begin n_fail++; $display("FAIL st_clr_g1 got %0d want 0", stat_grant1); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_round_robin();
    test_arb_en();
    test_reset_mid();
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xpmwrap_dpdistram_porta_arbiter.md
Name: xpmwrap_dpdistram_porta_arbiter

Overview:
Two-requester round-robin arbiter that shares the byte-writable port A of a dual-port distributed RAM (2-cycle read latency, common clock). It accepts read and byte-masked write requests over valid/ready, issues at most one RAM access per cycle and returns read data to the originating requester. Port B of the RAM is outside this block.

Parameters:
ADDR_WIDTH, 6, port A address width
DATA_WIDTH, 32, data width of RAM port A
BYTE_WIDTH, 8, bits per byte-enable lane; DATA_WIDTH must be a multiple of it; NBE = DATA_WIDTH/BYTE_WIDTH (derived localparam)

Ports:
clk  in  1  single clock for arbiter and RAM port A
rst_n  in  1  asynchronous active-low reset
arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight reads complete
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 granted this cycle
req0_we  in  NBE  byte write mask; all-zero = read
req0_addr  in  ADDR_WIDTH  address
req0_wdata  in  DATA_WIDTH  write data
rsp0_valid  out  1  read data valid for requester 0
rsp0_data  out  DATA_WIDTH  read data
req1_* / rsp1_*  same as requester 0
ram_ena  out  1  to RAM ena
ram_wea  out  NBE  to RAM wea
ram_addra  out  ADDR_WIDTH  to RAM addra
ram_dina  out  DATA_WIDTH  to RAM dina
ram_regcea  out  1  to RAM regcea; tied 1
ram_rsta  out  1  to RAM rsta; equals ~rst_n
ram_douta  in  DATA_WIDTH  from RAM douta

Behaviour:
- Reset (async assert, sync release): last_grant = 1 (requester 0 wins first tie), tag pipeline cleared, rsp*_valid = 0, rsp*_data = 0, stats counters = 0.
- Grant (combinational from registered last_grant): if arb_en = 0 no grant. Only one valid: grant it. Both valid: grant the requester != last_grant. last_grant updates on every grant.
- reqN_ready = grant to N; handshake completes when valid & ready in the same cycle; requester holds all fields stable while valid & !ready.
- RAM drive: ram_ena = any grant; ram_addra/ram_dina/ram_wea = granted requester's fields, combinational; idle cycles: ena = 0, wea = 0, addr/din = 0.
- Read tracking: 2-stage shift register of {is_read, id}, loaded on each grant (is_read = (we == 0)).
- A read granted in cycle N raises rspID_valid for exactly one cycle at N+2, with rspID_data = ram_douta; the other response is valid 0.
- rsp*_data holds its last value while valid = 0.
- Writes produce no response. Back-to-back reads every cycle give one response per cycle, in order.
- Read after write to the same address in cycle N+1 returns the new data (RAM write-first semantics on port A); the arbiter adds no hazard logic.
- arb_en deasserted mid-stream: no new grants; already-issued reads still return at N+2.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid until new reads are issued.
- No response backpressure: requesters must accept rsp_valid unconditionally.

Optional Feature:
XPMWRAP_DPDISTRAM_ARB_STATS_EN:
- Defined: adds outputs stat_grant0, stat_grant1, stat_conflict (16 bits each), plus input stat_clr.
- stat_grantN counts grants to requester N; stat_conflict counts cycles where both requesters are valid and arb_en = 1.
- All counters saturate at 0xFFFF. stat_clr zeroes them synchronously and takes priority over increments in the same cycle.
- Not defined: these ports and counters are absent, and core behaviour is identical.

Test Plan:
- Reset, then req0 writes addr 5 data 0xDEADBEEF we 4'hF; later req1 reads addr 5 -> rsp1_valid exactly 2 cycles after grant, data 0xDEADBEEF, rsp0_valid stays 0.
- Byte write: req0 writes addr 3 with 0x11223344 (we 4'hF), then addr 3 with 0xAABBCCDD (we 4'b0010); read addr 3 -> 0x1122CC44.
- Both requesters hold reads for 6 cycles -> grants alternate 0,1,0,1,0,1; responses alternate with 2-cycle offset, each data matching its own address.
- arb_en = 0 while both valid -> no ready and ram_ena = 0; read issued the cycle before deassert still returns at N+2.
- Assert rst_n low at N+1 after a read grant at N -> no rsp_valid at N+2; first grant after release goes to requester 0.
- With XPMWRAP_DPDISTRAM_ARB_STATS_EN: 4 conflict cycles -> stat_conflict = 4, stat_grant0 = 2, stat_grant1 = 2; stat_clr -> all 0 next cycle.
